// File: rtl/fp_aligner.sv
// fp_aligner: pre-add alignment stage of the binary32 FP adder datapath.
//
// Takes two IEEE-754 single-precision operands, orders them by magnitude and
// right-shifts the smaller significand by the exponent difference. The
// results leave through a two-register valid/ready pipeline.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  input handshake for the operand pair in_a / in_b
//   out_valid/ready output handshake for the aligned result
//   out_mant_large  significand of the larger operand, hidden bit at [23]
//   out_mant_small  smaller significand shifted right by the exponent gap
//   out_exp         exponent of the larger operand (common exponent)
//   out_sign_large  sign of the larger operand
//   out_sign_small  sign of the smaller operand
//   out_eff_sub     operand signs differ
//   out_sticky      OR of every bit shifted out of the smaller significand
module fp_aligner (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_mant_large,
    output logic [23:0] out_mant_small,
    output logic [7:0]  out_exp,
    output logic        out_sign_large,
    output logic        out_sign_small,
    output logic        out_eff_sub,
    output logic        out_sticky
);

    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic        a_is_large;

    logic        s1_valid;
    logic [23:0] s1_sig_large;
    logic [23:0] s1_sig_small;
    logic [7:0]  s1_exp_large;
    logic [7:0]  s1_diff;
    logic        s1_sign_large;
    logic        s1_sign_small;
    logic        s1_eff_sub;

    logic        s1_advance;
    logic        s2_advance;

    logic        big_shift;
    logic [23:0] shift_mask;
    logic [23:0] shifted_small;
    logic        sticky_next;

    // Zero exponent flushes zeros and denormals to a zero significand;
    // Inf/NaN are treated as ordinary large values.
    assign exp_a = in_a[30:23];
    assign exp_b = in_b[30:23];
    assign sig_a = (exp_a == 8'd0) ? 24'd0 : {1'b1, in_a[22:0]};
    assign sig_b = (exp_b == 8'd0) ? 24'd0 : {1'b1, in_b[22:0]};

    // Exponent is the major key, significand the minor; a tie keeps A large.
    assign a_is_large = ({exp_a, sig_a} >= {exp_b, sig_b});

    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;

    // Any gap of 24 or more pushes the whole significand into the sticky
    // bit; below that the low five bits of the gap are the shift amount.
    assign big_shift     = (s1_diff >= 8'd24);
    assign shift_mask    = ~(24'hFF_FFFF << s1_diff[4:0]);
    assign shifted_small = big_shift ? 24'd0 : (s1_sig_small >> s1_diff[4:0]);
    assign sticky_next   = big_shift ? (|s1_sig_small)
                                     : (|(s1_sig_small & shift_mask));

    // Stage 1: order the operands and register the exponent gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sig_large  <= 24'd0;
            s1_sig_small  <= 24'd0;
            s1_exp_large  <= 8'd0;
            s1_diff       <= 8'd0;
            s1_sign_large <= 1'b0;
            s1_sign_small <= 1'b0;
            s1_eff_sub    <= 1'b0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_eff_sub <= in_a[31] ^ in_b[31];
                if (a_is_large) begin
                    s1_sig_large  <= sig_a;
                    s1_sig_small  <= sig_b;
                    s1_exp_large  <= exp_a;
                    s1_diff       <= exp_a - exp_b;
                    s1_sign_large <= in_a[31];
                    s1_sign_small <= in_b[31];
                end else begin
                    s1_sig_large  <= sig_b;
                    s1_sig_small  <= sig_a;
                    s1_exp_large  <= exp_b;
                    s1_diff       <= exp_b - exp_a;
                    s1_sign_large <= in_b[31];
                    s1_sign_small <= in_a[31];
                end
            end
        end
    end

    // Stage 2: perform the alignment shift; outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_mant_large <= 24'd0;
            out_mant_small <= 24'd0;
            out_exp        <= 8'd0;
            out_sign_large <= 1'b0;
            out_sign_small <= 1'b0;
            out_eff_sub    <= 1'b0;
            out_sticky     <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant_large <= s1_sig_large;
                out_mant_small <= shifted_small;
                out_exp        <= s1_exp_large;
                out_sign_large <= s1_sign_large;
                out_sign_small <= s1_sign_small;
                out_eff_sub    <= s1_eff_sub;
                out_sticky     <= sticky_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_aligner.sv
// tb_fp_aligner: scoreboard bench for fp_aligner.
//
// The driver offers operand pairs; every accepted pair pushes its expected
// result (from a directed constant or the arithmetic reference model) into
// a queue. An independent monitor pops and compares whenever a result is
// consumed, and checks that outputs hold while the pipeline is stalled.
module tb_fp_aligner;

    typedef struct packed {
        logic [23:0] ml;
        logic [23:0] ms;
        logic [7:0]  e;
        logic        sl;
        logic        ss;
        logic        eff;
        logic        st;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant_large;
    logic [23:0] out_mant_small;
    logic [7:0]  out_exp;
    logic        out_sign_large;
    logic        out_sign_small;
    logic        out_eff_sub;
    logic        out_sticky;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   drv_directed = 0;
    exp_t drv_exp = '0;
    bit   stall_seen = 0;
    exp_t stall_snap = '0;
    bit   rand_done = 0;

    fp_aligner dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mant_large (out_mant_large),
        .out_mant_small (out_mant_small),
        .out_exp        (out_exp),
        .out_sign_large (out_sign_large),
        .out_sign_small (out_sign_small),
        .out_eff_sub    (out_eff_sub),
        .out_sticky     (out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: magnitude is exponent * 2^24 + significand; the shifted
    // value is floor(sig / 2^diff) and sticky is a nonzero remainder.
    function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        longint unsigned ea, eb, ma, mb, sig_s, pow, diff;
        bit a_large;
        ea = longint'(a[30:23]);
        eb = longint'(b[30:23]);
        ma = (ea == 0) ? 0 : (64'h80_0000 + longint'(a[22:0]));
        mb = (eb == 0) ? 0 : (64'h80_0000 + longint'(b[22:0]));
        a_large = (ea * 64'h100_0000 + ma) >= (eb * 64'h100_0000 + mb);
        r.eff = a[31] ^ b[31];
        if (a_large) begin
            r.ml = ma[23:0]; sig_s = mb; r.e = ea[7:0]; diff = ea - eb;
            r.sl = a[31]; r.ss = b[31];
        end else begin
            r.ml = mb[23:0]; sig_s = ma; r.e = eb[7:0]; diff = eb - ea;
            r.sl = b[31]; r.ss = a[31];
        end
        if (diff > 40) diff = 40;
        pow  = 64'd1 << diff;
        r.ms = 24'(sig_s / pow);
        r.st = (sig_s % pow) != 0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [23:0] ml, input logic [23:0] ms, input logic [7:0] e,
                                input logic sl, input logic ss, input logic eff, input logic st);
        exp_t r;
        r.ml = ml; r.ms = ms; r.e = e; r.sl = sl; r.ss = ss; r.eff = eff; r.st = st;
        return r;
    endfunction

    // Monitor: decisions are made at the falling edge for the next rising edge.
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = {out_mant_large, out_mant_small, out_exp, out_sign_large,
               out_sign_small, out_eff_sub, out_sticky};
        if (stall_seen)
            check("stall_hold", 32'(cur ^ stall_snap), 32'd0);
        stall_seen = out_valid && !out_ready && !rst;
        stall_snap = cur;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("mant_large", 32'(out_mant_large), 32'(e.ml));
                    check("mant_small", 32'(out_mant_small), 32'(e.ms));
                    check("exp",        32'(out_exp),        32'(e.e));
                    check("sign_large", 32'(out_sign_large), 32'(e.sl));
                    check("sign_small", 32'(out_sign_small), 32'(e.ss));
                    check("eff_sub",    32'(out_eff_sub),    32'(e.eff));
                    check("sticky",     32'(out_sticky),     32'(e.st));
                end
            end
            if (in_valid && in_ready)
                sb.push_back(drv_directed ? drv_exp : refModel(in_a, in_b));
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input bit directed, input exp_t de);
        bit acc;
        int n;
        in_a = a; in_b = b; in_valid = 1'b1;
        drv_directed = directed; drv_exp = de;
        acc = 0; n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_outs_zero"}, 32'({out_mant_large, out_mant_small, out_exp, out_sign_large,
                                        out_sign_small, out_eff_sub, out_sticky} != 0), 32'd0);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] randOperand(input logic [31:0] other);
        logic [31:0] v;
        int          mode;
        int          e;
        v = $urandom;
        mode = $urandom_range(0, 5);
        case (mode)
            0, 1: begin
                e = int'(other[30:23]) + $urandom_range(0, 60) - 30;
                if (e < 0) e = 0;
                if (e > 255) e = 255;
                v[30:23] = 8'(e);
            end
            2: v[30:23] = 8'd0;
            3: v = {$urandom_range(0, 1) == 1, other[30:0]};
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset");

        applyStimulus(32'h3F80_0000, 32'h3F00_0000, 1, mk(24'h80_0000, 24'h40_0000, 8'h7F, 0, 0, 0, 0));
        applyStimulus(32'h3F00_0000, 32'hBF80_0000, 1, mk(24'h80_0000, 24'h40_0000, 8'h7F, 1, 0, 1, 0));
        applyStimulus(32'h4B80_0000, 32'h3F80_0001, 1, mk(24'h80_0000, 24'h00_0000, 8'h97, 0, 0, 0, 1));
        applyStimulus(32'h4B80_0000, 32'h4A80_0001, 1, mk(24'h80_0000, 24'h20_0000, 8'h97, 0, 0, 0, 1));
        applyStimulus(32'h4040_0000, 32'h0000_0000, 1, mk(24'hC0_0000, 24'h00_0000, 8'h80, 0, 0, 0, 0));
        applyStimulus(32'h4000_0000, 32'hC000_0000, 1, mk(24'h80_0000, 24'h80_0000, 8'h80, 0, 1, 1, 0));
        applyStimulus(32'h8000_0000, 32'h0000_0000, 1, mk(24'h00_0000, 24'h00_0000, 8'h00, 1, 0, 1, 0));
        waitDrain();

        // Backpressure: two pairs fill the pipe, the third waits.
        out_ready = 1'b0;
        applyStimulus(32'h4120_0000, 32'h3F80_0000, 0, '0);
        applyStimulus(32'hC2C8_0000, 32'h4000_0001, 0, '0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        fork
            applyStimulus(32'h3E80_0000, 32'h3F40_0000, 0, '0);
            begin
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        waitDrain();

        // Reset with both stages holding data discards them.
        out_ready = 1'b0;
        applyStimulus(32'h4000_0000, 32'h3F80_0000, 0, '0);
        applyStimulus(32'h4100_0000, 32'h3F80_0000, 0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("midreset");
        out_ready = 1'b1;
        applyStimulus(32'h3F80_0000, 32'h3F00_0000, 1, mk(24'h80_0000, 24'h40_0000, 8'h7F, 0, 0, 0, 0));
        waitDrain();

        // Randomized traffic with random downstream backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = $urandom;
                    if ($urandom_range(0, 7) == 0) ra[30:23] = 8'd0;
                    rb = randOperand(ra);
                    if ($urandom_range(0, 1) == 1) applyStimulus(ra, rb, 0, '0);
                    else applyStimulus(rb, ra, 0, '0);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
